alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Shares one instance of the team's combinational alu block between two requesters.
- Requester 0 is the execute stage; requester 1 is the branch/address-calc unit.
- Round-robin arbitration with valid/ready request and response handshakes.
- Operands are registered, the ALU runs on the registered operands, and the result is held until the owning requester consumes it.

Parameters:
- WIDTH, 32, operand/result width; must match alu (only 32 supported).
- RESET_PRIO, 0, requester favoured first after reset (0 or 1).

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_req_valid  input  2  per-requester request valid; bit n = requester n.
- o_req_ready  output  2  per-requester accept; at most one bit set.
- i_req_ctl0, i_req_ctl1  input  4 each  alu_ctl code per requester.
- i_req_a0, i_req_b0, i_req_a1, i_req_b1  input  WIDTH each  operands.
- o_rsp_valid  output  2  response valid; at most one bit set.
- i_rsp_ready  input  2  per-requester response accept.
- o_rsp_result  output  WIDTH  registered ALU result, shared bus.
- o_rsp_zero  output  1  registered zero flag (result == 0).

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values:
  - o_req_ready = 0, o_rsp_valid = 0, o_rsp_result = 0, o_rsp_zero = 0.
  - Priority pointer = RESET_PRIO; owner = 0.
- IDLE:
  - o_req_ready[g] = 1 (combinational) for the granted requester g only.
  - With one requester valid, it is granted.
  - With both valid, g = priority pointer.
  - Handshake (valid & ready): latch ctl/a/b of g, owner <= g, go EXEC. Otherwise stay.
- EXEC:
  - o_req_ready = 0.
  - alu is driven from the latched regs.
  - At the clock edge, o_rsp_result and o_rsp_zero are registered; go RESP.
- RESP:
  - o_rsp_valid[owner] = 1; result/zero held stable.
  - On i_rsp_ready[owner]: pointer <= ~owner, go IDLE.
  - i_rsp_ready of the non-owner is ignored.
- Latency: request accepted at edge N; o_rsp_valid high from the cycle after edge N+1. Minimum 3 cycles per op with no response stall.
- No new request is accepted in EXEC or RESP.
- Requesters hold valid/ctl/operands stable until ready; dropping valid before ready is permitted; the request is simply not taken.
- The pointer updates only on response completion, so a single active requester is served back-to-back.
- ALU codes:
  - 0 AND, 1 OR, 2 ADD (mod 2^32), 6 SUB (mod 2^32).
  - 7 unsigned less-than, result 1/0.
  - 12 NOR.
  - Other codes: result 0, zero 1. This is not an error.
- Asynchronous reset mid-operation discards latched operands and any pending response; all outputs return to reset values immediately.

Optional Feature:
- Macro: ALU_SHARE_ARB_PERF_EN.
- Defined:
  - Adds output o_conflict_cnt [15:0], reset 0.
  - Increments by 1 each IDLE cycle where both i_req_valid bits are 1.
  - Saturates at 16'hFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package alu_pkg:
  - ALU control constants: ALU_AND = 0, ALU_OR = 1, ALU_ADD = 2, ALU_SUB = 6, ALU_SLTU = 7, ALU_NOR = 12.
  - FSM state typedef (IDLE/EXEC/RESP).
- Sub-module: rr_arb2, a 2-way round-robin grant (inputs: req[1:0], pointer; output: one-hot grant). alu is instantiated as-is.

Test Plan:
- Single request: req0 ADD, a = 5, b = 7, rsp_ready = 1 -> ready0 at accept, rsp_valid[0] two edges later, result = 12, zero = 0.
- Simultaneous requests after reset (RESET_PRIO = 0): req0 SUB 9-9, req1 OR 0xF0|0x0F -> req0 served first (result 0, zero 1); then req1 (result 0xFF); no overlap of rsp_valid bits.
- Response stall: req1 SLTU a = 3, b = 0xFFFFFFFF, hold i_rsp_ready = 0 for 5 cycles -> rsp_valid[1] and result 1 stable throughout; ready stays 0 for both requesters; release -> IDLE.
- Wrap/unknown codes: ADD 0xFFFFFFFF + 1 -> result 0, zero 1; ctl = 4 -> result 0, zero 1.
- Reset mid-op: assert i_rst_n = 0 during EXEC -> all outputs 0 immediately; after release, pointer = RESET_PRIO; pending op not reported.
- PERF_EN: both valid for 4 IDLE cycles (3 ops serialized) -> o_conflict_cnt = 4; without the macro, the build has no port.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, datapath width and the
// arbiter FSM state type used by alu_share_arb.
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_NOR  = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // One-hot encoding of a requester index (0 -> 2'b01, 1 -> 2'b10).
    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. Unknown control codes yield a zero result,
// which also raises the zero flag; that is normal operation, not an error.
module alu
    import alu_pkg::*;
(
    input  logic [3:0]       alu_ctl,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    output logic [ALU_W-1:0] result,
    output logic             zero
);

    // Operation select; arithmetic wraps modulo 2^32.
    always_comb begin
        result = '0;
        case (alu_ctl)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLTU: result = {{(ALU_W-1){1'b0}}, (a < b)};
            ALU_NOR:  result = ~(a | b);
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way round-robin grant. A lone requester always wins; when both
// request, the pointer names the winner. Grant is one-hot or zero.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant
            // Requester gi wins if the other is idle or the pointer favours gi.
            assign grant[gi] = req[gi] & (~req[1-gi] | (ptr == 1'(gi)));
        end
    endgenerate

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one combinational alu between the execute stage
// (requester 0) and the branch/address-calc unit (requester 1).
// Flow per operation: IDLE (grant + latch operands) -> EXEC (alu runs on
// the latched operands, result registered) -> RESP (held until the owner
// takes it). The round-robin pointer moves only when a response completes.
// Optional build macro ALU_SHARE_ARB_PERF_EN adds o_conflict_cnt, a
// saturating count of IDLE cycles in which both requesters were valid.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,    // must equal ALU_W; only 32 is supported
    parameter bit RESET_PRIO = 1'b0   // requester favoured first after reset
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_req_valid,
    output logic [1:0]       o_req_ready,
    input  logic [3:0]       i_req_ctl0,
    input  logic [3:0]       i_req_ctl1,
    input  logic [WIDTH-1:0] i_req_a0,
    input  logic [WIDTH-1:0] i_req_b0,
    input  logic [WIDTH-1:0] i_req_a1,
    input  logic [WIDTH-1:0] i_req_b1,
    output logic [1:0]       o_rsp_valid,
    input  logic [1:0]       i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_result,
    output logic             o_rsp_zero
`ifdef ALU_SHARE_ARB_PERF_EN
    ,
    output logic [15:0]      o_conflict_cnt
`endif
);

    arb_state_e       state_reg, state_next;
    logic             ptr_reg;
    logic             owner_reg;
    logic [3:0]       ctl_reg;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;

    logic [1:0]       grant;
    logic [1:0]       owner_onehot;
    logic             accept;
    logic             rsp_done;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    rr_arb2 u_rr_arb2 (
        .req   (i_req_valid),
        .ptr   (ptr_reg),
        .grant (grant)
    );

    alu u_alu (
        .alu_ctl (ctl_reg),
        .a       (a_reg),
        .b       (b_reg),
        .result  (alu_result),
        .zero    (alu_zero)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_owner
            assign owner_onehot[gi] = (owner_reg == 1'(gi));
        end
    endgenerate

    // grant only ever names a valid requester, so any grant in IDLE is a handshake
    assign accept   = (state_reg == IDLE) && (grant != 2'b00);
    assign rsp_done = (state_reg == RESP) && i_rsp_ready[owner_reg];

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)   state_next = EXEC;
            EXEC:                  state_next = RESP;
            RESP:    if (rsp_done) state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // FSM outputs; ready is also held low while reset is asserted so no
    // requester sees a handshake during reset
    always_comb begin
        o_req_ready = 2'b00;
        o_rsp_valid = 2'b00;
        if (state_reg == IDLE && i_rst_n) begin
            o_req_ready = grant;
        end
        if (state_reg == RESP) begin
            o_rsp_valid = owner_onehot;
        end
    end

    // Operand capture, result register and round-robin pointer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_reg    <= RESET_PRIO;
            owner_reg  <= 1'b0;
            ctl_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            zero_reg   <= 1'b0;
        end else begin
            if (accept) begin
                owner_reg <= grant[1];
                ctl_reg   <= grant[1] ? i_req_ctl1 : i_req_ctl0;
                a_reg     <= grant[1] ? i_req_a1   : i_req_a0;
                b_reg     <= grant[1] ? i_req_b1   : i_req_b0;
            end
            if (state_reg == EXEC) begin
                result_reg <= alu_result;
                zero_reg   <= alu_zero;
            end
            if (rsp_done) begin
                ptr_reg <= ~owner_reg;
            end
        end
    end

    assign o_rsp_result = result_reg;
    assign o_rsp_zero   = zero_reg;

`ifdef ALU_SHARE_ARB_PERF_EN
    logic [15:0] conflict_cnt_reg;

    // Saturating count of IDLE cycles with both requesters contending
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            conflict_cnt_reg <= '0;
        end else if (state_reg == IDLE && i_req_valid == 2'b11 &&
                     conflict_cnt_reg != 16'hFFFF) begin
            conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
        end
    end

    assign o_conflict_cnt = conflict_cnt_reg;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: reset, single ops, arbitration order,
// response stall, wrap/unknown codes, reset mid-operation and (when
// ALU_SHARE_ARB_PERF_EN is defined) the conflict counter.
module tb_alu_share_arb;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  ctl0, ctl1;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
`ifdef ALU_SHARE_ARB_PERF_EN
    logic [15:0] conflict_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    alu_share_arb #(
        .WIDTH      (32),
        .RESET_PRIO (1'b0)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_ctl0   (ctl0),
        .i_req_ctl1   (ctl1),
        .i_req_a0     (a0),
        .i_req_b0     (b0),
        .i_req_a1     (a1),
        .i_req_b1     (b1),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_result (rsp_result),
        .o_rsp_zero   (rsp_zero)
`ifdef ALU_SHARE_ARB_PERF_EN
        ,
        .o_conflict_cnt (conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        if (r == 1) begin
            ctl1 = ctl; a1 = a; b1 = b;
        end else begin
            ctl0 = ctl; a0 = a; b0 = b;
        end
    endtask

    // One uncontended operation with the response taken immediately.
    task automatic do_op(input int r, input logic [3:0] ctl, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input logic exp_zero);
        logic [1:0] bitv;
        bitv = (r == 1) ? 2'b10 : 2'b01;
        set_req(r, ctl, a, b);
        req_valid = bitv;
        rsp_ready = 2'b11;
        #1;
        check("op_idle_ready", 32'(req_ready), 32'(bitv));
        tick();
        req_valid = 2'b00;
        #1;
        check("op_exec_ready", 32'(req_ready), 32'h0);
        check("op_exec_rsp_valid", 32'(rsp_valid), 32'h0);
        tick();
        check("op_rsp_valid", 32'(rsp_valid), 32'(bitv));
        check("op_result", rsp_result, exp_res);
        check("op_zero", 32'(rsp_zero), 32'(exp_zero));
        $display("op req=%0d ctl=%0d a=0x%08h b=0x%08h result=0x%08h zero=%0b",
                 r, ctl, a, b, rsp_result, rsp_zero);
        tick();
        check("op_done_rsp_valid", 32'(rsp_valid), 32'h0);
    endtask

    initial begin
        // reset asserted with both requesters already valid
        rst_n = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
        ctl0 = '0; ctl1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_result", rsp_result, 32'h0);
        check("rst_zero", 32'(rsp_zero), 32'h0);
        tick(); tick();
        req_valid = 2'b00;
        rst_n = 1'b1;
        tick();

        // single request: 5 + 7
        do_op(0, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0);

        // re-reset so the pointer is back at RESET_PRIO
        rst_n = 1'b0; #1 rst_n = 1'b1; #1;

        // simultaneous requests: requester 0 first, then 1
        set_req(0, ALU_SUB, 32'd9, 32'd9);
        set_req(1, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
        req_valid = 2'b11; rsp_ready = 2'b11;
        #1;
        check("both_first_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b10;
        #1;
        check("both_exec_ready", 32'(req_ready), 32'h0);
        tick();
        check("both_rsp0_valid", 32'(rsp_valid), 32'h1);
        check("both_rsp0_result", rsp_result, 32'h0);
        check("both_rsp0_zero", 32'(rsp_zero), 32'h1);
        $display("op req=0 ctl=%0d result=0x%08h zero=%0b", ALU_SUB, rsp_result, rsp_zero);
        req_valid = 2'b11;
        tick();
        check("both_second_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        tick();
        check("both_rsp1_valid", 32'(rsp_valid), 32'h2);
        check("both_rsp1_result", rsp_result, 32'h0000_00FF);
        check("both_rsp1_zero", 32'(rsp_zero), 32'h0);
        $display("op req=1 ctl=%0d result=0x%08h zero=%0b", ALU_OR, rsp_result, rsp_zero);
        tick();
        check("both_done_rsp_valid", 32'(rsp_valid), 32'h0);

        // response stall on requester 1, requester 0 waiting meanwhile
        set_req(1, ALU_SLTU, 32'd3, 32'hFFFF_FFFF);
        req_valid = 2'b10; rsp_ready = 2'b00;
        #1;
        check("stall_grant1", 32'(req_ready), 32'h2);
        tick();
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        req_valid = 2'b01;
        #1;
        check("stall_exec_ready", 32'(req_ready), 32'h0);
        tick();
        rsp_ready = 2'b01;  // non-owner's ready must be ignored
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_rsp_valid", 32'(rsp_valid), 32'h2);
            check("stall_result", rsp_result, 32'h1);
            check("stall_zero", 32'(rsp_zero), 32'h0);
            check("stall_req_ready", 32'(req_ready), 32'h0);
            tick();
        end
        $display("op req=1 ctl=%0d result=0x%08h zero=%0b (after stall)", ALU_SLTU, rsp_result, rsp_zero);
        rsp_ready = 2'b10;
        tick();
        check("stall_release_grant0", 32'(req_ready), 32'h1);
        rsp_ready = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        check("stall_next_valid", 32'(rsp_valid), 32'h1);
        check("stall_next_result", rsp_result, 32'd12);
        tick();
        check("stall_next_done", 32'(rsp_valid), 32'h0);

        // wrap, unknown code and remaining operations
        do_op(0, ALU_ADD,  32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);
        do_op(1, ALU_NOR,  32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
        do_op(0, 4'd4,     32'd5, 32'd7, 32'h0, 1'b1);
        do_op(1, ALU_SUB,  32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0);
        do_op(1, ALU_SLTU, 32'hFFFF_FFFF, 32'd3, 32'h0, 1'b1);
        do_op(0, ALU_AND,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0);

        // reset during EXEC (pointer is 1 at this point)
        set_req(1, ALU_ADD, 32'd1, 32'd1);
        req_valid = 2'b10; rsp_ready = 2'b11;
        tick();
        req_valid = 2'b11;
        #1;
        check("midrst_exec_ready", 32'(req_ready), 32'h0);
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", 32'(req_ready), 32'h0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("midrst_result", rsp_result, 32'h0);
        check("midrst_zero", 32'(rsp_zero), 32'h0);
        tick(); tick();
        req_valid = 2'b00;
        rst_n = 1'b1;
        tick(); tick();
        check("midrst_no_rsp", 32'(rsp_valid), 32'h0);
        check("midrst_no_result", rsp_result, 32'h0);
        req_valid = 2'b11;
        #1;
        check("midrst_ptr_reset", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        tick();
        check("midrst_op_valid", 32'(rsp_valid), 32'h1);
        check("midrst_op_result", rsp_result, 32'h0F00_0F00);
        tick();

`ifdef ALU_SHARE_ARB_PERF_EN
        rst_n = 1'b0;
        #1;
        check("perf_reset", 32'(conflict_cnt), 32'h0);
        rst_n = 1'b1;
        req_valid = 2'b11; rsp_ready = 2'b11;
        repeat (10) tick();
        req_valid = 2'b00;
        check("perf_count", 32'(conflict_cnt), 32'd4);
        $display("perf conflict_cnt=%0d", conflict_cnt);
        repeat (3) tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
